// File: rtl/zigzag_buffer.sv
`default_nettype none
// ============================================================================
// Module      : zigzag_buffer
// Description : Ping-pong 8x8 block buffer. Captures one row of 8 quantized
//               coefficients per write strobe and re-emits each completed
//               block one coefficient per cycle in JPEG zigzag order over a
//               valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module zigzag_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,          // synchronous, active-high
    input  logic              enable_y,
    input  logic              enable_cb,
    input  logic              enable_cr,
    input  logic              enable_zzscan,
    input  logic [DATA_W-1:0] output_01,
    input  logic [DATA_W-1:0] output_02,
    input  logic [DATA_W-1:0] output_03,
    input  logic [DATA_W-1:0] output_04,
    input  logic [DATA_W-1:0] output_05,
    input  logic [DATA_W-1:0] output_06,
    input  logic [DATA_W-1:0] output_07,
    input  logic [DATA_W-1:0] output_08,
    output logic              in_ready,
    output logic              zz_valid,
    input  logic              zz_ready,
    output logic [DATA_W-1:0] zz_data,
    output logic [5:0]        zz_index,
    output logic              zz_last,
    output logic [1:0]        zz_comp,
    output logic              overflow
);

    // Zigzag position -> raster address within the 8x8 block
    localparam logic [5:0] c_zz_rom [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    localparam logic [1:0] c_comp_y    = 2'd0;
    localparam logic [1:0] c_comp_cb   = 2'd1;
    localparam logic [1:0] c_comp_cr   = 2'd2;
    localparam logic [1:0] c_comp_none = 2'd3;

    // Storage: address = {bank, row, col}; contents are never reset
    logic [DATA_W-1:0] r_mem [0:127];

    // Write-side state
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic [2:0]        r_wr_row;
    logic [1:0]        r_comp [0:1];
    logic              r_overflow;

    // Read-side state and registered stream outputs
    logic              r_rd_bank;
    logic [5:0]        r_rd_idx;
    logic              r_zz_valid;
    logic [DATA_W-1:0] r_zz_data;
    logic [5:0]        r_zz_index;
    logic              r_zz_last;
    logic [1:0]        r_zz_comp;

    // Combinational helpers
    logic [DATA_W-1:0] w_row [0:7];
    logic              w_in_ready;
    logic              w_wr_en;
    logic              w_wr_last_row;
    logic [1:0]        w_comp_in;
    logic              w_advance;
    logic              w_rd_done;
    logic [6:0]        w_rd_addr;
    logic [1:0]        w_full_next;

    // Gather the row inputs and derive handshake / bank bookkeeping
    always_comb begin
        w_row[0]      = output_01;
        w_row[1]      = output_02;
        w_row[2]      = output_03;
        w_row[3]      = output_04;
        w_row[4]      = output_05;
        w_row[5]      = output_06;
        w_row[6]      = output_07;
        w_row[7]      = output_08;

        w_in_ready    = ~r_full[r_wr_bank];
        w_wr_en       = enable_zzscan & w_in_ready;
        w_wr_last_row = (r_wr_row == 3'd7);

        if (enable_y)       w_comp_in = c_comp_y;
        else if (enable_cb) w_comp_in = c_comp_cb;
        else if (enable_cr) w_comp_in = c_comp_cr;
        else                w_comp_in = c_comp_none;

        w_advance     = (~r_zz_valid | zz_ready) & r_full[r_rd_bank];
        w_rd_done     = w_advance & (r_rd_idx == 6'd63);
        w_rd_addr     = {r_rd_bank, c_zz_rom[r_rd_idx]};

        // Set and clear always address different banks, so order is irrelevant
        w_full_next   = r_full;
        if (w_rd_done)
            w_full_next[r_rd_bank] = 1'b0;
        if (w_wr_en && w_wr_last_row)
            w_full_next[r_wr_bank] = 1'b1;
    end

    // Row write into the current write bank
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < 8; k++)
                r_mem[{r_wr_bank, r_wr_row, 3'(k)}] <= w_row[k];
        end
    end

    // Write-side counters, full flags, per-bank component id and overflow
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_full     <= 2'b00;
            r_wr_bank  <= 1'b0;
            r_wr_row   <= 3'd0;
            r_comp[0]  <= c_comp_y;
            r_comp[1]  <= c_comp_y;
            r_overflow <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_wr_en) begin
                if (r_wr_row == 3'd0)
                    r_comp[r_wr_bank] <= w_comp_in;
                r_wr_row <= r_wr_row + 3'd1;
                if (w_wr_last_row)
                    r_wr_bank <= ~r_wr_bank;
            end
            if (enable_zzscan && !w_in_ready)
                r_overflow <= 1'b1;
        end
    end

    // Read-side output register: load next zigzag coefficient on advance
    always_ff @(posedge clk) begin
        if (nrst) begin
            r_rd_bank  <= 1'b0;
            r_rd_idx   <= 6'd0;
            r_zz_valid <= 1'b0;
            r_zz_data  <= '0;
            r_zz_index <= 6'd0;
            r_zz_last  <= 1'b0;
            r_zz_comp  <= 2'd0;
        end else if (w_advance) begin
            r_zz_valid <= 1'b1;
            r_zz_data  <= r_mem[w_rd_addr];
            r_zz_index <= r_rd_idx;
            r_zz_last  <= (r_rd_idx == 6'd63);
            r_zz_comp  <= r_comp[r_rd_bank];
            r_rd_idx   <= r_rd_idx + 6'd1;
            if (w_rd_done)
                r_rd_bank <= ~r_rd_bank;
        end else if (zz_ready) begin
            // Nothing new to load and the held beat was taken
            r_zz_valid <= 1'b0;
        end
    end

    assign in_ready = w_in_ready;
    assign zz_valid = r_zz_valid;
    assign zz_data  = r_zz_data;
    assign zz_index = r_zz_index;
    assign zz_last  = r_zz_last;
    assign zz_comp  = r_zz_comp;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_zigzag_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_zigzag_buffer
// Description : Directed self-checking bench for zigzag_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zigzag_buffer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       enable_y, enable_cb, enable_cr, enable_zzscan;
    logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
    logic       in_ready;
    logic       zz_valid;
    logic       zz_ready;
    logic [7:0] zz_data;
    logic [5:0] zz_index;
    logic       zz_last;
    logic [1:0] zz_comp;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    int zz_tab [0:63] = '{
        0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    zigzag_buffer #(.DATA_W(8)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .enable_y      (enable_y),
        .enable_cb     (enable_cb),
        .enable_cr     (enable_cr),
        .enable_zzscan (enable_zzscan),
        .output_01     (o1),
        .output_02     (o2),
        .output_03     (o3),
        .output_04     (o4),
        .output_05     (o5),
        .output_06     (o6),
        .output_07     (o7),
        .output_08     (o8),
        .in_ready      (in_ready),
        .zz_valid      (zz_valid),
        .zz_ready      (zz_ready),
        .zz_data       (zz_data),
        .zz_index      (zz_index),
        .zz_last       (zz_last),
        .zz_comp       (zz_comp),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample/drive point is 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe nrows rows; row r col c carries base + r*8 + c
    task automatic write_block(input int base, input logic y, input logic cb,
                               input logic cr, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            enable_zzscan = 1'b1;
            enable_y = y; enable_cb = cb; enable_cr = cr;
            o1 = 8'(base + r*8 + 0); o2 = 8'(base + r*8 + 1);
            o3 = 8'(base + r*8 + 2); o4 = 8'(base + r*8 + 3);
            o5 = 8'(base + r*8 + 4); o6 = 8'(base + r*8 + 5);
            o7 = 8'(base + r*8 + 6); o8 = 8'(base + r*8 + 7);
            step();
        end
        enable_zzscan = 1'b0;
        enable_y = 1'b0; enable_cb = 1'b0; enable_cr = 1'b0;
    endtask

    // Consume n beats; beats 0..63 use (b0,c0), 64..127 use (b1,c1)
    task automatic drain(input int n, input int b0, input logic [1:0] c0,
                         input int b1, input logic [1:0] c1,
                         input logic [3:0] pat, input bit no_gap);
        int beat = 0;
        int cyc  = 0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [7:0] pd = '0;
        logic [5:0] pi = '0;
        logic [7:0] ed;
        logic [1:0] ec;
        int idx;
        while (beat < n && cyc < n*4 + 20) begin
            zz_ready = pat[cyc % 4];
            if (pv && !pr) begin
                checks++;
                if (zz_valid !== 1'b1 || zz_data !== pd || zz_index !== pi) begin
                    failures++;
                    $display("FAIL stall_hold: valid=%0b data=%0d idx=%0d, required valid=1 data=%0d idx=%0d",
                             zz_valid, zz_data, zz_index, pd, pi);
                end
            end
            if (no_gap) begin
                checks++;
                if (zz_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL no_gap beat %0d: valid=%0b, required 1", beat, zz_valid);
                end
            end
            if (zz_valid === 1'b1 && zz_ready === 1'b1) begin
                idx = beat % 64;
                ed  = (beat < 64) ? 8'(zz_tab[idx] + b0) : 8'(zz_tab[idx] + b1);
                ec  = (beat < 64) ? c0 : c1;
                checks++;
                if (zz_data !== ed || zz_index !== 6'(idx) ||
                    zz_last !== (idx == 63) || zz_comp !== ec) begin
                    failures++;
                    $display("FAIL beat %0d: data=%0d idx=%0d last=%0b comp=%0d, required data=%0d idx=%0d last=%0b comp=%0d",
                             beat, zz_data, zz_index, zz_last, zz_comp, ed, idx, (idx == 63), ec);
                end
                beat++;
            end
            pv = zz_valid; pr = zz_ready; pd = zz_data; pi = zz_index;
            step();
            cyc++;
        end
        checks++;
        if (beat != n) begin
            failures++;
            $display("FAIL drain_count: got %0d beats, required %0d", beat, n);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; zz_ready = 1'b0;
        step(); step();
        nrst = 1'b0;
        checks++;
        if (zz_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1 ||
            zz_index !== 6'd0 || zz_last !== 1'b0 || zz_comp !== 2'd0 || zz_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%0b ovf=%0b in_ready=%0b idx=%0d last=%0b comp=%0d data=%0d, required 0 0 1 0 0 0 0",
                     zz_valid, overflow, in_ready, zz_index, zz_last, zz_comp, zz_data);
        end
    endtask

    task automatic test_single_block();
        zz_ready = 1'b1;
        write_block(0, 1'b1, 1'b0, 1'b0, 8);
        checks++;
        if (zz_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: valid=%0b in_ready=%0b one edge after row 7 write, required 0 1",
                     zz_valid, in_ready);
        end
        step();
        checks++;
        if (zz_valid !== 1'b1 || zz_data !== 8'd0 || zz_index !== 6'd0) begin
            failures++;
            $display("FAIL single_first: valid=%0b data=%0d idx=%0d, required 1 0 0",
                     zz_valid, zz_data, zz_index);
        end
        drain(64, 0, 2'd0, 0, 2'd0, 4'b1111, 1'b1);
        checks++;
        if (zz_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_end: valid=%0b in_ready=%0b, required 0 1", zz_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        zz_ready = 1'b0;
        write_block(0, 1'b1, 1'b0, 1'b0, 8);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready_mid: in_ready=%0b after 8 strobes, required 1", in_ready);
        end
        write_block(64, 1'b0, 1'b0, 1'b1, 8);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ready_full: in_ready=%0b after 16 strobes, required 0", in_ready);
        end
        // Third block while both banks are full must be discarded
        write_block(170, 1'b1, 1'b0, 1'b0, 1);
        checks++;
        if (overflow !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL overflow_set: ovf=%0b in_ready=%0b, required 1 0", overflow, in_ready);
        end
        write_block(178, 1'b1, 1'b0, 1'b0, 7);
        drain(128, 0, 2'd0, 64, 2'd2, 4'b1111, 1'b1);
        checks++;
        if (overflow !== 1'b1 || zz_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: ovf=%0b valid=%0b in_ready=%0b, required 1 0 1",
                     overflow, zz_valid, in_ready);
        end
    endtask

    task automatic test_stall();
        zz_ready = 1'b0;
        write_block(3, 1'b0, 1'b1, 1'b0, 8);
        step();
        drain(64, 3, 2'd1, 0, 2'd0, 4'b1001, 1'b0);
        checks++;
        if (zz_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_end: valid=%0b, required 0", zz_valid);
        end
    endtask

    task automatic test_mid_reset();
        zz_ready = 1'b0;
        write_block(0, 1'b1, 1'b0, 1'b0, 8);
        zz_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        write_block(100, 1'b0, 1'b0, 1'b1, 5);
        nrst = 1'b1;
        step();
        nrst = 1'b0;
        checks++;
        if (zz_valid !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b1 || zz_index !== 6'd0) begin
            failures++;
            $display("FAIL mid_reset: valid=%0b ovf=%0b in_ready=%0b idx=%0d, required 0 0 1 0",
                     zz_valid, overflow, in_ready, zz_index);
        end
        zz_ready = 1'b0;
        write_block(128, 1'b0, 1'b1, 1'b0, 8);
        step();
        checks++;
        if (zz_valid !== 1'b1 || zz_index !== 6'd0 || zz_data !== 8'd128) begin
            failures++;
            $display("FAIL post_reset_first: valid=%0b idx=%0d data=%0d, required 1 0 128",
                     zz_valid, zz_index, zz_data);
        end
        drain(64, 128, 2'd1, 0, 2'd0, 4'b1111, 1'b0);
    endtask

    initial begin
        nrst = 1'b1;
        enable_y = 1'b0; enable_cb = 1'b0; enable_cr = 1'b0; enable_zzscan = 1'b0;
        o1 = '0; o2 = '0; o3 = '0; o4 = '0; o5 = '0; o6 = '0; o7 = '0; o8 = '0;
        zz_ready = 1'b0;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
